// File: rtl/mux_arb2_pkg.sv
// Shared defaults, source ids and state encoding for the two-input arbitrating mux.
package mux_arb2_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_BURST_LEN = 4;

    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/mux2_1.sv
// Plain two-way data selector: s=0 picks d0, s=1 picks d1.
module mux2_1 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             s,
    output logic [WIDTH-1:0] y
);

    assign y = s ? d1 : d0;

endmodule

// File: rtl/rr_pick2.sv
// Grant decision for two requesters; optional burst rule selected by MUX_ARB2_BURST_EN.
module rr_pick2
    import mux_arb2_pkg::*;
#(
    parameter int BURST_LEN = DEF_BURST_LEN
) (
    input  logic                               v0,
    input  logic                               v1,
    input  logic                               last,
    input  logic [$clog2(BURST_LEN+1)-1:0]     count,
    output logic                               grant,
    output logic                               any
);

    logic contend_win;

`ifdef MUX_ARB2_BURST_EN
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    // Keep granting the previous winner until its burst allowance is spent.
    assign contend_win = (count < CNT_W'(BURST_LEN)) ? last : ~last;
`else
    logic unused_count;
    assign unused_count = ^count;
    assign contend_win  = ~last;
`endif

    always_comb begin
        grant = SRC0;
        if (v0 && v1) begin
            grant = contend_win;
        end else if (v1) begin
            grant = SRC1;
        end
    end

    assign any = v0 | v1;

endmodule

// File: rtl/mux_arb2.sv
// Two-requester arbitrated mux with a one-word registered output stage.
// Define MUX_ARB2_BURST_EN to let a winner keep up to BURST_LEN consecutive grants.
module mux_arb2
    import mux_arb2_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int BURST_LEN = DEF_BURST_LEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d0,
    input  logic             v0,
    output logic             r0,
    input  logic [WIDTH-1:0] d1,
    input  logic             v1,
    output logic             r1,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    input  logic             y_ready,
    output logic             y_src
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             src_q, src_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] count_q;

    logic             grant;
    logic             any;
    logic             load;
    logic             take;
    logic [WIDTH-1:0] sel_data;

`ifdef MUX_ARB2_BURST_EN
    logic [CNT_W-1:0] count_d;
`endif

    rr_pick2 #(
        .BURST_LEN (BURST_LEN)
    ) u_pick (
        .v0    (v0),
        .v1    (v1),
        .last  (last_q),
        .count (count_q),
        .grant (grant),
        .any   (any)
    );

    mux2_1 #(
        .WIDTH (WIDTH)
    ) u_mux (
        .d0 (d0),
        .d1 (d1),
        .s  (grant),
        .y  (sel_data)
    );

    // Readies are suppressed while reset is held, even though the stage reads as empty.
    always_comb begin
        load = (state_q == EMPTY) || y_ready;
        take = load && any;
        r0   = rst_n && take && (grant == SRC0);
        r1   = rst_n && take && (grant == SRC1);
    end

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        src_d   = src_q;
        last_d  = last_q;
        if (load) begin
            if (any) begin
                state_d = FULL;
                y_d     = sel_data;
                src_d   = grant;
                last_d  = grant;
            end else begin
                state_d = EMPTY;
            end
        end
    end

`ifdef MUX_ARB2_BURST_EN
    always_comb begin
        count_d = count_q;
        if (take) begin
            if (grant == last_q) begin
                count_d = (count_q == CNT_W'(BURST_LEN)) ? count_q : count_q + 1'b1;
            end else begin
                count_d = CNT_W'(1);
            end
        end
    end
`else
    assign count_q = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            y_q     <= '0;
            src_q   <= SRC0;
            last_q  <= SRC1;
`ifdef MUX_ARB2_BURST_EN
            count_q <= CNT_W'(BURST_LEN);
`endif
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            src_q   <= src_d;
            last_q  <= last_d;
`ifdef MUX_ARB2_BURST_EN
            count_q <= count_d;
`endif
        end
    end

    assign y       = y_q;
    assign y_valid = (state_q == FULL);
    assign y_src   = src_q;

endmodule

// File: tb/tb_mux_arb2.sv
// Self-checking bench for mux_arb2: directed scenarios then random traffic against a reference model.
module tb_mux_arb2;

    localparam int BL = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] d0, d1;
    logic       v0, v1;
    logic       r0, r1;
    logic [7:0] y;
    logic       y_valid;
    logic       y_ready;
    logic       y_src;

    int vectors;
    int miscompares;

    bit       m_valid;
    bit [7:0] m_y;
    bit       m_src;
    int       m_last;
    int       m_streak;
    bit       exp_r0, exp_r1;

    mux_arb2 #(
        .WIDTH     (8),
        .BURST_LEN (BL)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .d0      (d0),
        .v0      (v0),
        .r0      (r0),
        .d1      (d1),
        .v1      (v1),
        .r1      (r1),
        .y       (y),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .y_src   (y_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic modelReset();
        m_valid  = 1'b0;
        m_y      = 8'h00;
        m_src    = 1'b0;
        m_last   = 1;
        m_streak = BL;
    endtask

    // Winner from the arbitration rules: -1 means nobody is asking.
    function automatic int pick(bit a, bit b);
        if (a && b) begin
`ifdef MUX_ARB2_BURST_EN
            if (m_streak < BL) return m_last;
            return 1 - m_last;
`else
            return 1 - m_last;
`endif
        end
        if (a) return 0;
        if (b) return 1;
        return -1;
    endfunction

    // Called at posedge+1: drive, check before the next edge, then advance the model.
    task automatic applyStimulus(input bit a0, input bit [7:0] da0,
                                 input bit a1, input bit [7:0] da1, input bit yr);
        bit load;
        int w;
        v0 = a0; d0 = da0; v1 = a1; d1 = da1; y_ready = yr;
        #3;
        load   = !m_valid || yr;
        w      = pick(a0, a1);
        exp_r0 = load && (w == 0);
        exp_r1 = load && (w == 1);
        checkOutput("r0", r0, exp_r0);
        checkOutput("r1", r1, exp_r1);
        checkOutput("y_valid", y_valid, m_valid);
        checkOutput("y", y, m_y);
        checkOutput("y_src", y_src, m_src);
        @(posedge clk);
        #1;
        if (load) begin
            if (w >= 0) begin
                m_valid = 1'b1;
                m_y     = (w == 1) ? da1 : da0;
                m_src   = (w == 1);
                if (w == m_last) m_streak = (m_streak < BL) ? m_streak + 1 : BL;
                else             m_streak = 1;
                m_last  = w;
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        v0 = 1'b1; v1 = 1'b1; d0 = 8'h11; d1 = 8'h22; y_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_y_valid", y_valid, 1'b0);
        checkOutput("rst_y", y, 8'h00);
        checkOutput("rst_y_src", y_src, 1'b0);
        checkOutput("rst_r0", r0, 1'b0);
        checkOutput("rst_r1", r1, 1'b0);
        rst_n = 1'b1;
        modelReset();
    endtask

    bit [7:0] seq_y [4];
    bit       seq_s [4];
    bit       p0, p1;
    bit [7:0] q0, q1;

    initial begin
        vectors = 0;
        miscompares = 0;
        modelReset();
        doReset();

        // Solo accept then idle drain.
        applyStimulus(1'b1, 8'h9A, 1'b0, 8'h00, 1'b1);
        checkOutput("solo_y", y, 8'h9A);
        checkOutput("solo_src", y_src, 1'b0);
        checkOutput("solo_valid", y_valid, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        checkOutput("drain_valid", y_valid, 1'b0);
        checkOutput("drain_hold", y, 8'h9A);
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        // Contention from reset.
        doReset();
`ifdef MUX_ARB2_BURST_EN
        seq_y = '{8'h9A, 8'h9A, 8'h9A, 8'h9A};
        seq_s = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        seq_y = '{8'h9A, 8'h75, 8'h9A, 8'h75};
        seq_s = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'h9A, 1'b1, 8'h75, 1'b1);
            checkOutput("cont_y", y, seq_y[i]);
            checkOutput("cont_src", y_src, seq_s[i]);
        end

        // Backpressure: held word stays, no readies.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'h9A, 1'b0, 8'h00, 1'b0);
            checkOutput("stall_y", y, seq_y[3]);
        end
        applyStimulus(1'b1, 8'h9A, 1'b0, 8'h00, 1'b1);
        checkOutput("unstall_y", y, 8'h9A);

`ifdef MUX_ARB2_BURST_EN
        doReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 8'h9A, 1'b1, 8'h75, 1'b1);
            checkOutput("burst_src", y_src, (i >= 4 && i < 8) ? 1'b1 : 1'b0);
        end
`endif

        // Asynchronous reset while a word is held.
        v0 = 1'b1; v1 = 1'b1; y_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_y_valid", y_valid, 1'b0);
        checkOutput("arst_y", y, 8'h00);
        checkOutput("arst_r0", r0, 1'b0);
        checkOutput("arst_r1", r1, 1'b0);
        modelReset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 8'h9A, 1'b1, 8'h75, 1'b1);
        checkOutput("arst_first_src", y_src, 1'b0);

        // Random traffic with occasional valid drops and backpressure.
        p0 = 1'b0; p1 = 1'b0; q0 = 8'h00; q1 = 8'h00;
        for (int i = 0; i < 2000; i++) begin
            if (!p0 && ($urandom % 3 == 0)) begin p0 = 1'b1; q0 = 8'($urandom); end
            else if (p0 && ($urandom % 16 == 0)) p0 = 1'b0;
            if (!p1 && ($urandom % 3 == 0)) begin p1 = 1'b1; q1 = 8'($urandom); end
            else if (p1 && ($urandom % 16 == 0)) p1 = 1'b0;
            applyStimulus(p0, q0, p1, q1, ($urandom % 4) != 0);
            if (exp_r0) p0 = 1'b0;
            if (exp_r1) p1 = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
